neopixel_strand_gen2: RTL and testbench

Parametrised, double-buffered NeoPixel (WS2812-class) strand driver. Pixel colours are written into a staging buffer at any time. `send_it` snapshots the staging buffer into a transmit frame, which is serialised onto `neo_data` with per-bit high/low pulse timing, followed by a latch (reset) gap. The block sits between the host/register logic and the strand's data pin. It generalises the 5-pixel RGB controller to N pixels, RGB or RGBW, and programmable timing.

---
 rtl/neopixel_strand_gen2_pkg.sv | 52 +++++
 rtl/neopixel_strand_gen2_if.sv | 36 +++
 rtl/counter.sv | 20 ++
 rtl/neopixel_bit_encoder.sv | 56 +++++
 rtl/neopixel_strand_gen2.sv | 147 ++++++++++++++
 tb/tb_neopixel_strand_gen2.sv | 391 +++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/neopixel_strand_gen2_pkg.sv
// Shared types and defaults for the NeoPixel strand driver.
// Colour slot order on the wire is G, R, B, W.
package neopixel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    LATCH
  } state_t;

  typedef logic [7:0] byte_t;

  localparam logic [1:0] CI_R = 2'b00;
  localparam logic [1:0] CI_B = 2'b01;
  localparam logic [1:0] CI_G = 2'b10;
  localparam logic [1:0] CI_W = 2'b11;

  localparam int DEF_T1H   = 35;
  localparam int DEF_T1L   = 30;
  localparam int DEF_T0H   = 18;
  localparam int DEF_T0L   = 40;
  localparam int DEF_LATCH = 2500;

  function automatic int slot_of(
    input logic [1:0] ci
  );
    int s;
    unique case (ci)
      CI_G:    s = 0;
      CI_R:    s = 1;
      CI_B:    s = 2;
      default: s = 3;
    endcase
    return s;
  endfunction

  function automatic int max_of(
    input int a, input int b,
    input int c, input int d,
    input int e
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/neopixel_strand_gen2_if.sv
// Host-side bundle of the strand driver.
// master = host/register logic, slave = driver.
interface neopixel_strand_gen2_if
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS = 8
);
  localparam int PW =
    (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  logic          load_color;
  logic [PW-1:0] pixel_index;
  logic [1:0]    color_index;
  byte_t         color_level;
  logic          send_it;
  logic          neo_data;
  logic          ready_to_load;
  logic          ready_to_send;
  logic          busy;

  modport master (
    output load_color, pixel_index,
    output color_index, color_level,
    output send_it,
    input  neo_data, ready_to_load,
    input  ready_to_send, busy
  );

  modport slave (
    input  load_color, pixel_index,
    input  color_index, color_level,
    input  send_it,
    output neo_data, ready_to_load,
    output ready_to_send, busy
  );
endinterface

// File: rtl/counter.sv
// Generic up-counter with synchronous clear.
// Clear wins over increment.
module counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end
endmodule

// File: rtl/neopixel_bit_encoder.sv
// One-bit pulse generator: high phase then low phase.
// done flags the last low cycle so the next bit can start seamlessly.
module neopixel_bit_encoder
  import neopixel_pkg::*;
#(
  parameter int T1H = DEF_T1H,
  parameter int T1L = DEF_T1L,
  parameter int T0H = DEF_T0H,
  parameter int T0L = DEF_T0L,
  parameter int CW  = 12
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic bit_val,
  output logic neo_data,
  output logic done
);
  localparam logic [CW-1:0] H1 = CW'(T1H - 1);
  localparam logic [CW-1:0] L1 = CW'(T1L - 1);
  localparam logic [CW-1:0] H0 = CW'(T0H - 1);
  localparam logic [CW-1:0] L0 = CW'(T0L - 1);

  logic          low;
  logic          bit_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      neo_data <= 1'b0;
      low      <= 1'b0;
      bit_q    <= 1'b0;
      cnt      <= '0;
    end else if (start) begin
      neo_data <= 1'b1;
      low      <= 1'b0;
      bit_q    <= bit_val;
      cnt      <= bit_val ? H1 : H0;
    end else if (neo_data) begin
      if (cnt == '0) begin
        neo_data <= 1'b0;
        low      <= 1'b1;
        cnt      <= bit_q ? L1 : L0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (low) begin
      if (cnt == '0)
        low <= 1'b0;
      else
        cnt <= cnt - 1'b1;
    end
  end

  assign done = low && (cnt == '0);
endmodule

// File: rtl/neopixel_strand_gen2.sv
// Double-buffered NeoPixel strand driver: staging buffer, frame
// snapshot, bit sequencing and latch gap.
module neopixel_strand_gen2
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS      = 8,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int T1H_CYC         = DEF_T1H,
  parameter int T1L_CYC         = DEF_T1L,
  parameter int T0H_CYC         = DEF_T0H,
  parameter int T0L_CYC         = DEF_T0L,
  parameter int LATCH_CYC       = DEF_LATCH
) (
  input logic clock,
  input logic reset_n,
  neopixel_strand_gen2_if.slave bus
);
  localparam int NB = NUM_PIXELS * BYTES_PER_PIXEL;
  localparam int FRAME_BITS = NB * 8;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int IW = $clog2(NB);
  localparam int LW = $clog2(LATCH_CYC + 1);
  localparam int CW = $clog2(max_of(T1H_CYC,
    T1L_CYC, T0H_CYC, T0L_CYC, LATCH_CYC) + 1);

  byte_t stage [NB];
  byte_t frame [NB];

  state_t        state, state_next;
  logic [BW-1:0] bit_cnt, nb;
  logic [LW-1:0] lat_cnt;
  logic [IW-1:0] widx;
  int            wslot;
  logic          wen, accept, start, last;
  logic          done, enc_neo, bit_val;
  logic          xmit, lat_done;
  logic          busy_q, rts_q;

  always_comb begin
    wslot = slot_of(bus.color_index);
    widx  = IW'(int'(bus.pixel_index)
      * BYTES_PER_PIXEL + wslot);
    wen   = bus.load_color
      && (int'(bus.pixel_index) < NUM_PIXELS)
      && (wslot < BYTES_PER_PIXEL);
  end

  // Snapshot reads staging before this edge's write lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NB; i++) begin
        stage[i] <= '0;
        frame[i] <= '0;
      end
    end else begin
      if (wen)
        stage[widx] <= bus.color_level;
      if (accept)
        frame <= stage;
    end
  end

  assign xmit = (state == HIGH) || (state == LOW);
  assign last = (bit_cnt == BW'(FRAME_BITS - 1));
  assign start = accept || (xmit && done && !last);
  assign lat_done = (state == LATCH)
    && (lat_cnt == LW'(LATCH_CYC - 1));

  // First bit comes straight from staging: frame loads this edge.
  always_comb begin
    nb = bit_cnt + 1'b1;
    bit_val = accept ? stage[0][7]
      : frame[IW'(nb >> 3)][~nb[2:0]];
  end

  counter #(.W(BW)) u_bit_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (accept),
    .inc     (xmit && done && !last),
    .count   (bit_cnt)
  );

  counter #(.W(LW)) u_lat_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (state != LATCH),
    .inc     (state == LATCH),
    .count   (lat_cnt)
  );

  neopixel_bit_encoder #(
    .T1H (T1H_CYC),
    .T1L (T1L_CYC),
    .T0H (T0H_CYC),
    .T0L (T0L_CYC),
    .CW  (CW)
  ) u_enc (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .bit_val  (bit_val),
    .neo_data (enc_neo),
    .done     (done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      rts_q  <= 1'b1;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
      rts_q  <= (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.send_it) begin
          accept     = 1'b1;
          state_next = HIGH;
        end
      end
      HIGH, LOW: begin
        if (done)
          state_next = last ? LATCH : HIGH;
        else if ((state == HIGH) && !enc_neo)
          state_next = LOW;
      end
      LATCH: begin
        if (lat_done)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.neo_data      = enc_neo;
  assign bus.busy          = busy_q;
  assign bus.ready_to_send = rts_q;
  assign bus.ready_to_load = 1'b1;
endmodule

// File: tb/tb_neopixel_strand_gen2.sv
// Bench: RGB strand (default timing) and RGBW strand (short timing)
// driven in parallel, pulse trains checked against a pixel model.
module tb_neopixel_strand_gen2;
  import neopixel_pkg::*;

  localparam int NA = 2;
  localparam int NBP = 3;
  localparam int FA = NA * 3 * 8;
  localparam int FB = NBP * 4 * 8;
  localparam int BT1H = 6, BT1L = 5;
  localparam int BT0H = 3, BT0L = 7;
  localparam int BLAT = 40;
  localparam int A1 = (35 << 16) | 30;
  localparam int A0 = (18 << 16) | 40;
  localparam int B1 = (BT1H << 16) | BT1L;
  localparam int B0 = (BT0H << 16) | BT0L;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       load_color = 1'b0;
  logic       send_a = 1'b0;
  logic       send_b = 1'b0;
  logic [1:0] pix = '0;
  logic [1:0] ci = '0;
  byte_t      lvl = '0;

  neopixel_strand_gen2_if #(.NUM_PIXELS(NA)) ia ();
  neopixel_strand_gen2_if #(.NUM_PIXELS(NBP)) ib ();

  assign ia.load_color  = load_color && (pix < 2'd2);
  assign ia.pixel_index = pix[0];
  assign ia.color_index = ci;
  assign ia.color_level = lvl;
  assign ia.send_it     = send_a;
  assign ib.load_color  = load_color;
  assign ib.pixel_index = pix;
  assign ib.color_index = ci;
  assign ib.color_level = lvl;
  assign ib.send_it     = send_b;

  neopixel_strand_gen2 #(
    .NUM_PIXELS(NA), .BYTES_PER_PIXEL(3)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ia.slave)
  );

  neopixel_strand_gen2 #(
    .NUM_PIXELS(NBP), .BYTES_PER_PIXEL(4),
    .T1H_CYC(BT1H), .T1L_CYC(BT1L),
    .T0H_CYC(BT0H), .T0L_CYC(BT0L),
    .LATCH_CYC(BLAT)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ib.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_a = 0, end_a = 0;

  byte_t mr [2][3];
  byte_t mg [2][3];
  byte_t mb [2][3];
  byte_t mw [2][3];
  logic [95:0] fa, fb;

  int qa[$], qb[$];
  int ha = 0, la = 0, hb = 0, lb = 0;
  logic pna = 0, pba = 0, pnb = 0, pbb = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      ha = 0; la = 0; pna = 0; pba = 0;
      qa.delete();
    end else begin
      if (pba && !ia.busy) begin
        if (ha > 0) qa.push_back((ha << 16) | la);
        ha = 0; la = 0; end_a = cyc;
      end else if (ia.neo_data && !pna) begin
        if (ha > 0) qa.push_back((ha << 16) | la);
        ha = 1; la = 0;
      end else if (ia.neo_data) ha++;
      else if (ha > 0) la++;
      pna = ia.neo_data; pba = ia.busy;
    end
  end

  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      hb = 0; lb = 0; pnb = 0; pbb = 0;
      qb.delete();
    end else begin
      if (pbb && !ib.busy) begin
        if (hb > 0) qb.push_back((hb << 16) | lb);
        hb = 0; lb = 0;
      end else if (ib.neo_data && !pnb) begin
        if (hb > 0) qb.push_back((hb << 16) | lb);
        hb = 1; lb = 0;
      end else if (ib.neo_data) hb++;
      else if (hb > 0) lb++;
      pnb = ib.neo_data; pbb = ib.busy;
    end
  end

  function automatic logic [95:0] build(input int d);
    logic [95:0] v;
    v = '0;
    if (d == 0) begin
      for (int p = 0; p < NA; p++)
        v = (v << 24) | {72'd0, mg[0][p], mr[0][p], mb[0][p]};
    end else begin
      for (int p = 0; p < NBP; p++)
        v = (v << 32) | {64'd0, mg[1][p], mr[1][p],
          mb[1][p], mw[1][p]};
    end
    return v;
  endfunction

  task automatic mdl_set(input int d, input int p,
    input int c, input byte_t l);
    case (c)
      0: mr[d][p] = l;
      1: mb[d][p] = l;
      2: mg[d][p] = l;
      default: mw[d][p] = l;
    endcase
  endtask

  task automatic mdl_write(input int p, input int c,
    input byte_t l);
    if (p < NA && c != 3) mdl_set(0, p, c, l);
    if (p < NBP) mdl_set(1, p, c, l);
  endtask

  task automatic mdl_clear();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 3; p++) begin
        mr[d][p] = 0; mg[d][p] = 0;
        mb[d][p] = 0; mw[d][p] = 0;
      end
  endtask

  task automatic do_write(input int p, input int c,
    input byte_t l);
    @(negedge clock);
    pix = 2'(p); ci = 2'(c); lvl = l;
    load_color = 1'b1;
    @(posedge clock); #1;
    load_color = 1'b0;
    mdl_write(p, c, l);
  endtask

  task automatic do_send(input bit sa, input bit sb,
    input bit wr, input int p, input int c, input byte_t l);
    @(negedge clock);
    if (sa) fa = build(0);
    if (sb) fb = build(1);
    send_a = sa; send_b = sb;
    if (wr) begin
      pix = 2'(p); ci = 2'(c); lvl = l;
      load_color = 1'b1;
    end
    @(posedge clock); #1;
    send_a = 0; send_b = 0; load_color = 0;
    if (wr) mdl_write(p, c, l);
    if (sa) begin
      st_a = cyc;
      checks++;
      if (ia.neo_data !== 1'b1 || ia.busy !== 1'b1
          || ia.ready_to_send !== 1'b0) begin
        errors++;
        $display("FAIL send_latency neo=%b busy=%b rts=%b want 1 1 0",
          ia.neo_data, ia.busy, ia.ready_to_send);
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((ia.busy || ib.busy) && n < 8000) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #2;
    if (n >= 8000) begin
      checks++; errors++;
      $display("FAIL %s_timeout busy=%b%b want 00",
        nm, ia.busy, ib.busy);
    end
  endtask

  task automatic check_frames(input string nm);
    int e;
    bit bad;
    checks++;
    bad = 0;
    if (qa.size() != FA) begin
      errors++;
      $display("FAIL %s_a pulses got %0d want %0d",
        nm, qa.size(), FA);
    end else begin
      for (int i = 0; i < FA; i++) begin
        e = fa[FA-1-i] ? A1 : A0;
        if (i == FA - 1) e += 2500;
        if (qa[i] !== e && !bad) begin
          bad = 1; errors++;
          $display("FAIL %s_a bit %0d got h%0d l%0d want h%0d l%0d",
            nm, i, qa[i] >> 16, qa[i] & 16'hffff,
            e >> 16, e & 16'hffff);
        end
      end
    end
    checks++;
    bad = 0;
    if (qb.size() != FB) begin
      errors++;
      $display("FAIL %s_b pulses got %0d want %0d",
        nm, qb.size(), FB);
    end else begin
      for (int i = 0; i < FB; i++) begin
        e = fb[FB-1-i] ? B1 : B0;
        if (i == FB - 1) e += BLAT;
        if (qb[i] !== e && !bad) begin
          bad = 1; errors++;
          $display("FAIL %s_b bit %0d got h%0d l%0d want h%0d l%0d",
            nm, i, qb[i] >> 16, qb[i] & 16'hffff,
            e >> 16, e & 16'hffff);
        end
      end
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic test_reset();
    mdl_clear();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ia.neo_data !== 0 || ia.busy !== 0
        || ia.ready_to_send !== 1 || ia.ready_to_load !== 1
        || ib.neo_data !== 0 || ib.busy !== 0) begin
      errors++;
      $display("FAIL reset_state a=%b%b%b%b b=%b%b want 0011 00",
        ia.neo_data, ia.busy, ia.ready_to_send,
        ia.ready_to_load, ib.neo_data, ib.busy);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (ia.ready_to_send !== 1 || ia.ready_to_load !== 1) begin
      errors++;
      $display("FAIL post_reset rts=%b rtl=%b want 1 1",
        ia.ready_to_send, ia.ready_to_load);
    end
  endtask

  task automatic test_all_zero();
    do_send(1, 1, 0, 0, 0, 0);
    wait_idle("all_zero");
    check_frames("all_zero");
    checks++;
    if (end_a - st_a != 2784 + 2500) begin
      errors++;
      $display("FAIL frame_duration got %0d want %0d",
        end_a - st_a, 2784 + 2500);
    end
    checks++;
    if (ia.ready_to_send !== 1'b1) begin
      errors++;
      $display("FAIL rts_after_frame got %b want 1",
        ia.ready_to_send);
    end
  endtask

  task automatic test_bit_order();
    do_write(0, 2, 8'h80);
    do_send(1, 1, 0, 0, 0, 0);
    wait_idle("bit_order");
    checks++;
    if (qa.size() == 0 || qa[0] !== A1) begin
      errors++;
      $display("FAIL bit_order_first got %0h want %0h",
        (qa.size() > 0) ? qa[0] : -1, A1);
    end
    check_frames("bit_order");
    do_write(0, 2, 8'h00);
  endtask

  task automatic test_rgbw();
    do_write(1, 3, 8'h01);
    do_send(1, 1, 0, 0, 0, 0);
    wait_idle("rgbw");
    check_frames("rgbw");
    do_write(1, 3, 8'h00);
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      for (int w = 0; w < 12; w++)
        do_write(int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          byte_t'($urandom));
      do_send(1, 1, 0, 0, 0, 0);
      wait_idle("random");
      check_frames("random");
    end
  endtask

  task automatic test_double_buffer();
    int n;
    do_send(1, 1, 0, 0, 0, 0);
    repeat (200) @(posedge clock);
    do_write(0, 2, byte_t'($urandom) ^ mg[0][0] | 8'h01);
    n = 0;
    while (qa.size() < 47 && n < 6000) begin
      @(posedge clock); #1;
      n++;
    end
    repeat (100) @(posedge clock);
    @(negedge clock);
    send_a = 1'b1;
    @(posedge clock); #1;
    send_a = 1'b0;
    wait_idle("dbuf");
    check_frames("dbuf_old");
    repeat (20) @(posedge clock);
    #1;
    checks++;
    if (ia.busy !== 1'b0 || qa.size() != 0) begin
      errors++;
      $display("FAIL latch_send_ignored busy=%b pulses=%0d want 0 0",
        ia.busy, qa.size());
    end
    do_send(1, 1, 0, 0, 0, 0);
    wait_idle("dbuf_new");
    check_frames("dbuf_new");
  endtask

  task automatic test_same_cycle();
    do_send(1, 1, 1, 1, 0, byte_t'($urandom) | 8'h80);
    wait_idle("same_cycle");
    check_frames("same_old");
    do_send(1, 1, 0, 0, 0, 0);
    wait_idle("same_cycle2");
    check_frames("same_new");
  endtask

  task automatic test_reset_mid();
    do_write(0, 0, 8'hff);
    do_write(2, 1, 8'hff);
    do_send(1, 1, 0, 0, 0, 0);
    repeat (300) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ia.neo_data !== 0 || ia.busy !== 0
        || ib.neo_data !== 0 || ib.busy !== 0) begin
      errors++;
      $display("FAIL reset_mid a=%b%b b=%b%b want 00 00",
        ia.neo_data, ia.busy, ib.neo_data, ib.busy);
    end
    mdl_clear();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    do_send(1, 1, 0, 0, 0, 0);
    wait_idle("after_reset");
    check_frames("after_reset");
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_bit_order();
    test_rgbw();
    test_random();
    test_double_buffer();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
